// File: rtl/branch_prediction_pkg.sv
// Shared constants and helpers for the branch predictor: RV64 control-flow
// opcodes, the 2-bit history counter type, immediate decoders and the saturating update rule.
package branch_prediction_pkg;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef logic [1:0] ctr2_t;

    // Weakly not-taken
    localparam ctr2_t CTR_RESET = 2'd1;

    function automatic logic [63:0] imm_j(input logic [31:0] ins);
        return {{44{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
    endfunction

    function automatic logic [63:0] imm_b(input logic [31:0] ins);
        return {{52{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
    endfunction

    function automatic ctr2_t ctr_sat_update(input ctr2_t c, input logic taken);
        if (taken) begin
            return (c == 2'd3) ? c : c + 2'd1;
        end
        return (c == 2'd0) ? c : c - 2'd1;
    endfunction

endpackage

// File: rtl/branch_prediction_counter_table.sv
// Table of 2-bit saturating branch history counters with one combinational
// read port and one registered update port.
module bp_counter_table
    import branch_prediction_pkg::*;
#(
    parameter int ENTRIES = 64,
    localparam int IDX_W  = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx_i,
    output ctr2_t            rd_ctr_o,
    input  logic             upd_valid_i,
    input  logic [IDX_W-1:0] upd_idx_i,
    input  logic             upd_taken_i
);

    ctr2_t ctr_q [ENTRIES];
    ctr2_t ctr_d;

    // Read sees the pre-update value when read and update hit the same entry
    assign rd_ctr_o = ctr_q[rd_idx_i];

    always_comb begin
        ctr_d = ctr_sat_update(ctr_q[upd_idx_i], upd_taken_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= CTR_RESET;
            end
        end else if (upd_valid_i) begin
            ctr_q[upd_idx_i] <= ctr_d;
        end
    end

endmodule

// File: rtl/branch_prediction.sv
// Zero-latency next-PC predictor for RV64 fetch. With BP_BHT_EN defined,
// branches use a 2-bit counter table; otherwise backward-taken static prediction.
module branch_prediction
    import branch_prediction_pkg::*;
#(
    parameter int BHT_ENTRIES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] pc,
    input  logic [31:0] instruction,
    input  logic        update_valid,
    input  logic [63:0] update_pc,
    input  logic        update_taken,
    output logic [63:0] next_pc,
    output logic        overwrite_pc
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    logic [6:0]  opcode;
    logic [63:0] j_target;
    logic [63:0] b_target;
    logic        br_taken;

    assign opcode   = instruction[6:0];
    assign j_target = pc + imm_j(instruction);
    assign b_target = pc + imm_b(instruction);

`ifdef BP_BHT_EN
    ctr2_t rd_ctr;
    logic  unused_upd_pc;

    bp_counter_table #(
        .ENTRIES(BHT_ENTRIES)
    ) u_table (
        .clk        (clk),
        .rst_n      (reset),
        .rd_idx_i   (pc[IDX_W+1:2]),
        .rd_ctr_o   (rd_ctr),
        .upd_valid_i(update_valid),
        .upd_idx_i  (update_pc[IDX_W+1:2]),
        .upd_taken_i(update_taken)
    );

    // Counter values 2 and 3 mean taken
    assign br_taken      = rd_ctr[1];
    assign unused_upd_pc = ^{update_pc[63:IDX_W+2], update_pc[1:0]};
`else
    logic unused_inputs;

    // Sign bit of the B-immediate: backward branches predicted taken
    assign br_taken      = instruction[31];
    assign unused_inputs = ^{clk, reset, update_valid, update_pc, update_taken};
`endif

    always_comb begin
        overwrite_pc = 1'b0;
        next_pc      = pc + 64'd4;
        case (opcode)
            OPC_JAL: begin
                overwrite_pc = 1'b1;
                next_pc      = j_target;
            end
            OPC_BRANCH: begin
                if (br_taken) begin
                    overwrite_pc = 1'b1;
                    next_pc      = b_target;
                end
            end
            OPC_JALR: begin
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_branch_prediction.sv
// Self-checking bench for branch_prediction: directed literal cases plus
// randomized traffic compared every cycle against a behavioural model.
module tb_branch_prediction;

    localparam int BHT_ENTRIES = 64;
    localparam logic [31:0] BEQ_BACK = 32'hFE000CE3;
    localparam logic [31:0] BEQ_FWD  = 32'h00000463;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [63:0] pc = 64'd0;
    logic [31:0] instruction = 32'd0;
    logic        update_valid = 1'b0;
    logic [63:0] update_pc = 64'd0;
    logic        update_taken = 1'b0;
    logic [63:0] next_pc;
    logic        overwrite_pc;

    int n_checks = 0;
    int n_pass   = 0;
    int bht [BHT_ENTRIES];

    logic        e_ov;
    logic [63:0] e_np;

    branch_prediction #(.BHT_ENTRIES(BHT_ENTRIES)) dut (
        .clk         (clk),
        .reset       (reset),
        .pc          (pc),
        .instruction (instruction),
        .update_valid(update_valid),
        .update_pc   (update_pc),
        .update_taken(update_taken),
        .next_pc     (next_pc),
        .overwrite_pc(overwrite_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%h, expected 0x%h (pc=0x%h ins=0x%h)", name, act, exp, pc, instruction);
    endtask

    // Reference: decode the instruction fields into signed offsets and pick the target
    function automatic void model(input logic [63:0] p, input logic [31:0] ins,
                                  output logic ov, output logic [63:0] np);
        longint signed off;
        bit taken;
        ov = 1'b0;
        np = p + 64'd4;
        if (ins[6:0] == 7'h6F) begin
            off = $signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0});
            ov  = 1'b1;
            np  = p + 64'(off);
        end else if (ins[6:0] == 7'h63) begin
            off = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
`ifdef BP_BHT_EN
            taken = bht[int'((p >> 2) % BHT_ENTRIES)] >= 2;
`else
            taken = off < 0;
`endif
            if (taken) begin
                ov = 1'b1;
                np = p + 64'(off);
            end
        end
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            for (int i = 0; i < BHT_ENTRIES; i++) bht[i] = 1;
        end
        model(pc, instruction, e_ov, e_np);
        chk("model_overwrite_pc", {63'd0, overwrite_pc}, {63'd0, e_ov});
        chk("model_next_pc", next_pc, e_np);
`ifdef BP_BHT_EN
        if (reset && update_valid) begin
            int k;
            k = int'((update_pc >> 2) % BHT_ENTRIES);
            if (update_taken) bht[k] = (bht[k] < 3) ? bht[k] + 1 : 3;
            else              bht[k] = (bht[k] > 0) ? bht[k] - 1 : 0;
        end
`endif
    end

    task automatic drive(input logic [63:0] p, input logic [31:0] ins,
                         input logic uv, input logic [63:0] up, input logic ut);
        @(posedge clk);
        #1;
        pc           = p;
        instruction  = ins;
        update_valid = uv;
        update_pc    = up;
        update_taken = ut;
        @(negedge clk);
        #1;
    endtask

    task automatic set_reset(input logic v);
        @(posedge clk);
        #1;
        reset = v;
    endtask

    initial begin
        logic [63:0] rp, ru;
        logic [31:0] ri;

        // Outputs stay live during reset, counters at weakly not-taken
        drive(64'h1000, 32'h0100006F, 1'b1, 64'h1000, 1'b1);
        chk("rst_jal_ov", {63'd0, overwrite_pc}, 64'd1);
        chk("rst_jal_npc", next_pc, 64'h1010);
        drive(64'h2000, BEQ_BACK, 1'b1, 64'h2000, 1'b1);
`ifdef BP_BHT_EN
        chk("rst_br_npc", next_pc, 64'h2004);
`else
        chk("rst_br_npc", next_pc, 64'h1FF8);
`endif
        set_reset(1'b1);

        drive(64'h1000, 32'h0100006F, 1'b0, 64'h0, 1'b0);
        chk("jal_ov", {63'd0, overwrite_pc}, 64'd1);
        chk("jal_npc", next_pc, 64'h1010);

`ifdef BP_BHT_EN
        drive(64'h2000, BEQ_BACK, 1'b0, 64'h0, 1'b0);
        chk("cold_ov", {63'd0, overwrite_pc}, 64'd0);
        chk("cold_npc", next_pc, 64'h2004);
        for (int i = 0; i < 2; i++) drive(64'h40, 32'h13, 1'b1, 64'h2000, 1'b1);
        drive(64'h2000, BEQ_BACK, 1'b0, 64'h0, 1'b0);
        chk("trained_ov", {63'd0, overwrite_pc}, 64'd1);
        chk("trained_npc", next_pc, 64'h1FF8);
        for (int i = 0; i < 3; i++) drive(64'h40, 32'h13, 1'b1, 64'h2000, 1'b0);
        drive(64'h2000, BEQ_BACK, 1'b0, 64'h0, 1'b0);
        chk("untrained_ov", {63'd0, overwrite_pc}, 64'd0);
        drive(64'h40, 32'h13, 1'b1, 64'h2000, 1'b1);
        drive(64'h2000, BEQ_BACK, 1'b1, 64'h2000, 1'b1);
        chk("same_cycle_ov", {63'd0, overwrite_pc}, 64'd0);
        drive(64'h2000, BEQ_BACK, 1'b0, 64'h0, 1'b0);
        chk("after_update_ov", {63'd0, overwrite_pc}, 64'd1);
        chk("after_update_npc", next_pc, 64'h1FF8);
`else
        drive(64'h2000, BEQ_BACK, 1'b0, 64'h0, 1'b0);
        chk("static_back_ov", {63'd0, overwrite_pc}, 64'd1);
        chk("static_back_npc", next_pc, 64'h1FF8);
        drive(64'h2000, BEQ_FWD, 1'b0, 64'h0, 1'b0);
        chk("static_fwd_ov", {63'd0, overwrite_pc}, 64'd0);
        chk("static_fwd_npc", next_pc, 64'h2004);
        for (int i = 0; i < 3; i++) drive(64'h2000, BEQ_FWD, 1'b1, 64'h2000, 1'b1);
        drive(64'h2000, BEQ_FWD, 1'b0, 64'h0, 1'b0);
        chk("static_ignores_update", next_pc, 64'h2004);
`endif

        drive(64'hFFFF_FFFF_FFFF_FFFC, 32'h00000013, 1'b0, 64'h0, 1'b0);
        chk("nop_wrap_ov", {63'd0, overwrite_pc}, 64'd0);
        chk("nop_wrap_npc", next_pc, 64'h0);
        drive(64'hFFFF_FFFF_FFFF_FFFC, 32'h00000000, 1'b0, 64'h0, 1'b0);
        chk("bubble_wrap_ov", {63'd0, overwrite_pc}, 64'd0);
        chk("bubble_wrap_npc", next_pc, 64'h0);
        drive(64'h3000, 32'h000080E7, 1'b0, 64'h0, 1'b0);
        chk("jalr_ov", {63'd0, overwrite_pc}, 64'd0);

        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) set_reset(1'b0);
            if (n == 1502) set_reset(1'b1);
            rp = {32'($urandom), 32'($urandom)};
            ru = {32'($urandom), 32'($urandom)};
            if ($urandom_range(0, 3) != 0) rp[7:0] = 8'($urandom_range(0, 7) << 2);
            if ($urandom_range(0, 3) != 0) ru[7:0] = 8'($urandom_range(0, 7) << 2);
            ri = $urandom;
            case ($urandom_range(0, 6))
                0:       ri[6:0] = 7'h6F;
                1, 2, 3: ri[6:0] = 7'h63;
                4:       ri[6:0] = 7'h67;
                5:       ri = ($urandom_range(0, 1) != 0) ? 32'h13 : 32'h0;
                default: ;
            endcase
            drive(rp, ri, 1'($urandom_range(0, 1)), ru, 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/branch_prediction.md
BRANCH_PREDICTION -- requirements
Module: branch_prediction

Interface
REQ-001 SHALL have parameter `BHT_ENTRIES`, default 64, meaning the number of 2-bit history counters (power of two, at least 2).
REQ-002 SHALL have port `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port `reset`, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port `pc`, input, 64 bits: address of the instruction being predicted, from the fetch pipeline register.
REQ-005 SHALL have port `instruction`, input, 32 bits: the RV64 instruction word at `pc`.
REQ-006 SHALL have port `update_valid`, input, 1 bit: a resolved conditional branch is reported this cycle.
REQ-007 SHALL have port `update_pc`, input, 64 bits: PC of the resolved branch.
REQ-008 SHALL have port `update_taken`, input, 1 bit: the resolved branch outcome.
REQ-009 SHALL have port `next_pc`, output, 64 bits: the predicted fetch address.
REQ-010 SHALL have port `overwrite_pc`, output, 1 bit: fetch shall be redirected to `next_pc`.

Function
REQ-011 SHALL compute `next_pc` and `overwrite_pc` combinationally from `pc`, `instruction` and the current counter state, with zero-cycle latency.
REQ-012 SHALL, for JAL (opcode 1101111), set `overwrite_pc` to 1 and `next_pc` to `pc` plus the sign-extended J-immediate.
REQ-013 SHALL, for BRANCH (opcode 1100011), compute the target as `pc` plus the sign-extended B-immediate, and redirect (`overwrite_pc`=1, `next_pc`=target) only when predicted taken.
REQ-014 SHALL predict a branch taken when its counter value is 2 or 3.
REQ-015 SHALL select the counter using index `pc[log2(BHT_ENTRIES)+1:2]`.
REQ-016 SHALL, for all other opcodes (JALR included), and for an all-zero instruction (bubble), set `overwrite_pc` to 0 and `next_pc` to `pc`+4.
REQ-017 SHALL set `next_pc` to `pc`+4 whenever `overwrite_pc` is 0.
REQ-018 SHALL perform all address arithmetic modulo 2^64, wrapping silently.
REQ-019 SHALL, when `update_valid` is 1 at a clock edge, saturating-increment the counter indexed by `update_pc` if `update_taken` is 1, otherwise saturating-decrement it.
REQ-020 SHALL saturate counters at 3 and at 0.
REQ-021 SHALL, when a prediction and an update address the same index in the same cycle, base the prediction on the pre-update counter value.

Reset
REQ-022 SHALL, while `reset` is 0, asynchronously set every counter to 1 (weakly not-taken).
REQ-023 SHALL ignore updates while in reset.
REQ-024 SHALL keep its outputs combinational during reset, following REQ-011 to REQ-017 with all counters at 1.

Configuration
REQ-025 SHALL implement the counter table and the update path only when macro `BP_BHT_EN` is defined.
REQ-026 SHALL, without `BP_BHT_EN`, predict branches statically: taken if the B-immediate is negative, not taken otherwise.
REQ-027 SHALL, without `BP_BHT_EN`, ignore the `update_valid`, `update_pc` and `update_taken` inputs.
REQ-028 SHALL treat JAL and non-control instructions identically with and without `BP_BHT_EN`.

Structure
REQ-029 SHALL place the opcode constants (JAL, BRANCH, JALR) and the 2-bit counter typedef in the shared package.
REQ-030 SHALL implement the counter array with its saturating update logic as one sub-module, `bp_counter_table`.

Verification
REQ-031 SHALL cover JAL: `pc`=0x1000, `instruction`=0x0100006F -> `overwrite_pc`=1, `next_pc`=0x1010.
REQ-032 SHALL cover a BHT-cold branch (with `BP_BHT_EN`): after reset, `pc`=0x2000, `instruction`=0xFE000CE3 (beq x0,x0,-8) -> `overwrite_pc`=0, `next_pc`=0x2004.
REQ-033 SHALL cover BHT training: apply two taken updates at `update_pc`=0x2000, then present the same branch -> `overwrite_pc`=1, `next_pc`=0x1FF8; then apply three not-taken updates -> `overwrite_pc`=0.
REQ-034 SHALL cover same-cycle update and prediction at index 0x2000 with counter at 1 and a taken update -> this cycle not taken, next cycle taken.
REQ-035 SHALL cover static mode (without `BP_BHT_EN`): 0xFE000CE3 at 0x2000 -> `next_pc`=0x1FF8; a forward beq at 0x2000 -> `next_pc`=0x2004.
REQ-036 SHALL cover non-control and bubble: `instruction`=0x00000013 or 0x00000000 at `pc`=0xFFFFFFFFFFFFFFFC -> `overwrite_pc`=0, `next_pc`=0x0 (wrap).
